// File: rtl/rx_line_assembler.sv
// rx_line_assembler: gathers ASCII digits into a line buffer and commits the line to the FIFO on CR.
// Optional macro RX_BACKSPACE_EN adds backspace/delete editing while collecting.
module rx_line_assembler #(
   parameter int DEPTH = 16,
   parameter int LEN_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       iRX_DATA,
   input  logic             iRX_VALID,
   input  logic             iFIFO_FULL,
   output logic             oWR_EN,
   output logic [7:0]       oWR_DATA,
   output logic             oCLEAN,
   output logic             oFINISH,
   output logic [LEN_W-1:0] oLINE_LEN,
   output logic             oOVERFLOW,
   output logic             oBUSY
);

   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_FLUSH   = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   localparam int               IDX_W   = $clog2(DEPTH);
   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

   logic [1:0]       r_state;
   logic [LEN_W-1:0] r_count;
   logic [LEN_W-1:0] r_rd_idx;
   logic [LEN_W-1:0] r_line_len;
   logic             r_overflow;
   logic             r_clean;
   logic [7:0]       r_buf [DEPTH];

   logic w_is_digit;
   logic w_is_clear;
   logic w_is_cr;
   logic w_has_room;
   logic w_collect_rx;
   logic w_store;
   logic w_flush;
   logic w_last;

   assign w_is_digit   = (iRX_DATA >= 8'h30) && (iRX_DATA <= 8'h39);
   assign w_is_clear   = (iRX_DATA == 8'h43) || (iRX_DATA == 8'h63);
   assign w_is_cr      = (iRX_DATA == 8'h0D);
   assign w_has_room   = (r_count < DEPTH_L);
   assign w_collect_rx = (r_state == ST_COLLECT) && iRX_VALID;
   assign w_store      = w_collect_rx && w_is_digit && w_has_room;
   assign w_flush      = (r_state == ST_FLUSH);
   assign w_last       = (r_rd_idx == r_count - 1'b1);

`ifdef RX_BACKSPACE_EN
   logic w_is_bs;
   assign w_is_bs = (iRX_DATA == 8'h08) || (iRX_DATA == 8'h7F);
`endif

   // Write enable is gated combinationally so a full FIFO never sees a strobe.
   assign oWR_EN    = w_flush && !iFIFO_FULL;
   assign oWR_DATA  = w_flush ? r_buf[r_rd_idx[IDX_W-1:0]] : 8'h00;
   assign oCLEAN    = r_clean;
   assign oFINISH   = (r_state == ST_DONE);
   assign oLINE_LEN = r_line_len;
   assign oOVERFLOW = r_overflow;
   assign oBUSY     = (r_state != ST_COLLECT);

   always_ff @(posedge clk) begin
      if (w_store) begin
         r_buf[r_count[IDX_W-1:0]] <= iRX_DATA;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_COLLECT;
         r_count    <= '0;
         r_rd_idx   <= '0;
         r_line_len <= '0;
         r_overflow <= 1'b0;
         r_clean    <= 1'b0;
      end else begin
         r_clean <= 1'b0;
         case (r_state)
            ST_COLLECT: begin
               if (iRX_VALID) begin
                  if (w_is_digit) begin
                     if (w_has_room) begin
                        r_count <= r_count + 1'b1;
                     end else begin
                        r_overflow <= 1'b1;
                     end
                  end else if (w_is_clear) begin
                     r_count    <= '0;
                     r_overflow <= 1'b0;
                     r_clean    <= 1'b1;
                  end else if (w_is_cr) begin
                     if (r_count != '0) begin
                        r_rd_idx <= '0;
                        r_state  <= ST_FLUSH;
                     end
                  end
`ifdef RX_BACKSPACE_EN
                  else if (w_is_bs) begin
                     if (r_count != '0) begin
                        r_count <= r_count - 1'b1;
                     end
                  end
`endif
               end
            end
            ST_FLUSH: begin
               // rd_idx only moves on an accepted write, so a stall simply holds.
               if (!iFIFO_FULL) begin
                  r_rd_idx <= r_rd_idx + 1'b1;
                  if (w_last) begin
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_line_len <= r_count;
               r_count    <= '0;
               r_state    <= ST_COLLECT;
            end
            default: begin
               r_state <= ST_COLLECT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_line_assembler.sv
// Bench for rx_line_assembler: cycle vector table, directed corner sequences, and randomized
// lines scored against a queue-based line model.
module tb_rx_line_assembler;

   localparam int DEPTH = 16;
   localparam int LEN_W = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [7:0]       iRX_DATA = 8'h00;
   logic             iRX_VALID = 1'b0;
   logic             iFIFO_FULL = 1'b0;
   logic             oWR_EN;
   logic [7:0]       oWR_DATA;
   logic             oCLEAN;
   logic             oFINISH;
   logic [LEN_W-1:0] oLINE_LEN;
   logic             oOVERFLOW;
   logic             oBUSY;

   rx_line_assembler #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .iRX_DATA   (iRX_DATA),
      .iRX_VALID  (iRX_VALID),
      .iFIFO_FULL (iFIFO_FULL),
      .oWR_EN     (oWR_EN),
      .oWR_DATA   (oWR_DATA),
      .oCLEAN     (oCLEAN),
      .oFINISH    (oFINISH),
      .oLINE_LEN  (oLINE_LEN),
      .oOVERFLOW  (oOVERFLOW),
      .oBUSY      (oBUSY)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int finish_cnt = 0;
   int clean_cnt = 0;
   bit sb_en = 1'b0;
   bit stall_mode = 1'b0;

   // Line model: the pending line, committed bytes awaiting the FIFO, and sticky flags.
   logic [7:0] exp_q[$];
   logic [7:0] m_line[$];
   bit         m_ovf = 1'b0;
   bit         m_busy = 1'b0;
   int         m_clean_exp = 0;
   int         m_fin_target = 0;
   int         m_last_len = 0;

   typedef struct {
      logic             vld;
      logic [7:0]       dat;
      logic             full;
      logic             wr;
      logic [7:0]       wd;
      logic             fin;
      logic             busy;
      logic             cln;
      logic             ovf;
      logic [LEN_W-1:0] len;
   } vec_t;

   vec_t vecs[$];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (oFINISH) finish_cnt++;
         if (oCLEAN) clean_cnt++;
         if (oWR_EN) check("wr_while_full", iFIFO_FULL, 0);
         if (sb_en && oWR_EN) begin
            check("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("wr_data", oWR_DATA, exp_q.pop_front());
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (stall_mode) iFIFO_FULL = ($urandom_range(0, 3) == 0);
      end
   end

   function automatic vec_t mk(logic vld, logic [7:0] dat, logic full, logic wr, logic [7:0] wd,
                               logic fin, logic busy, logic cln, logic ovf, logic [LEN_W-1:0] len);
      vec_t v;
      v.vld = vld; v.dat = dat; v.full = full; v.wr = wr; v.wd = wd;
      v.fin = fin; v.busy = busy; v.cln = cln; v.ovf = ovf; v.len = len;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_rx(logic [7:0] b);
      if (m_busy) return;
      if (b >= 8'h30 && b <= 8'h39) begin
         if (m_line.size() < DEPTH) m_line.push_back(b);
         else m_ovf = 1'b1;
      end else if (b == 8'h43 || b == 8'h63) begin
         m_line.delete();
         m_ovf = 1'b0;
         m_clean_exp++;
      end else if (b == 8'h0D) begin
         if (m_line.size() > 0) begin
            foreach (m_line[i]) exp_q.push_back(m_line[i]);
            m_last_len = m_line.size();
            m_line.delete();
            m_busy = 1'b1;
            m_fin_target++;
         end
      end
`ifdef RX_BACKSPACE_EN
      else if (b == 8'h08 || b == 8'h7F) begin
         if (m_line.size() > 0) m_line.delete(m_line.size() - 1);
      end
`endif
   endtask

   task automatic send_byte(logic [7:0] b);
      iRX_VALID = 1'b1;
      iRX_DATA  = b;
      model_rx(b);
      tick();
      iRX_VALID = 1'b0;
      iRX_DATA  = 8'($urandom_range(0, 255));
   endtask

   task automatic send_str(string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_line_done(string tag);
      for (int i = 0; i < 400 && finish_cnt < m_fin_target; i++) tick();
      check({tag, "_finish"}, finish_cnt, m_fin_target);
      check({tag, "_len"}, oLINE_LEN, m_last_len);
      check({tag, "_drained"}, exp_q.size(), 0);
      check({tag, "_busy"}, oBUSY, 0);
      exp_q.delete();
      m_busy = 1'b0;
      m_fin_target = finish_cnt;
   endtask

   task automatic check_flags(string tag);
      check({tag, "_ovf"}, oOVERFLOW, m_ovf);
      check({tag, "_clean_cnt"}, clean_cnt, m_clean_exp);
   endtask

   initial begin
      logic [7:0] junk[5];
      int         seen;
      int         n;
      int         r;
      junk[0] = 8'h0A; junk[1] = 8'h41; junk[2] = 8'h20; junk[3] = 8'h08; junk[4] = 8'h7F;

      // Reset values
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_wr_en", oWR_EN, 0);
      check("rst_wr_data", oWR_DATA, 8'h00);
      check("rst_clean", oCLEAN, 0);
      check("rst_finish", oFINISH, 0);
      check("rst_line_len", oLINE_LEN, 0);
      check("rst_overflow", oOVERFLOW, 0);
      check("rst_busy", oBUSY, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Cycle-accurate table: basic commit, back-pressure, clear-then-CR.
      //                vld dat    full wr wd     fin busy cln ovf len
      vecs.push_back(mk(1, 8'h31, 0,   0, 8'h00, 0,  0,   0,  0,  0));
      vecs.push_back(mk(1, 8'h32, 0,   0, 8'h00, 0,  0,   0,  0,  0));
      vecs.push_back(mk(1, 8'h33, 0,   0, 8'h00, 0,  0,   0,  0,  0));
      vecs.push_back(mk(1, 8'h0D, 0,   0, 8'h00, 0,  0,   0,  0,  0));
      vecs.push_back(mk(0, 8'h00, 0,   1, 8'h31, 0,  1,   0,  0,  0));
      vecs.push_back(mk(0, 8'h00, 0,   1, 8'h32, 0,  1,   0,  0,  0));
      vecs.push_back(mk(0, 8'h00, 0,   1, 8'h33, 0,  1,   0,  0,  0));
      vecs.push_back(mk(0, 8'h00, 0,   0, 8'h00, 1,  1,   0,  0,  0));
      vecs.push_back(mk(0, 8'h00, 0,   0, 8'h00, 0,  0,   0,  0,  3));
      vecs.push_back(mk(1, 8'h34, 0,   0, 8'h00, 0,  0,   0,  0,  3));
      vecs.push_back(mk(1, 8'h35, 0,   0, 8'h00, 0,  0,   0,  0,  3));
      vecs.push_back(mk(1, 8'h36, 0,   0, 8'h00, 0,  0,   0,  0,  3));
      vecs.push_back(mk(1, 8'h37, 0,   0, 8'h00, 0,  0,   0,  0,  3));
      vecs.push_back(mk(1, 8'h0D, 0,   0, 8'h00, 0,  0,   0,  0,  3));
      vecs.push_back(mk(0, 8'h00, 0,   1, 8'h34, 0,  1,   0,  0,  3));
      vecs.push_back(mk(0, 8'h00, 0,   1, 8'h35, 0,  1,   0,  0,  3));
      vecs.push_back(mk(0, 8'h00, 1,   0, 8'h00, 0,  1,   0,  0,  3));
      vecs.push_back(mk(0, 8'h00, 1,   0, 8'h00, 0,  1,   0,  0,  3));
      vecs.push_back(mk(0, 8'h00, 1,   0, 8'h00, 0,  1,   0,  0,  3));
      vecs.push_back(mk(0, 8'h00, 0,   1, 8'h36, 0,  1,   0,  0,  3));
      vecs.push_back(mk(0, 8'h00, 0,   1, 8'h37, 0,  1,   0,  0,  3));
      vecs.push_back(mk(0, 8'h00, 0,   0, 8'h00, 1,  1,   0,  0,  3));
      vecs.push_back(mk(0, 8'h00, 0,   0, 8'h00, 0,  0,   0,  0,  4));
      vecs.push_back(mk(1, 8'h35, 0,   0, 8'h00, 0,  0,   0,  0,  4));
      vecs.push_back(mk(1, 8'h35, 0,   0, 8'h00, 0,  0,   0,  0,  4));
      vecs.push_back(mk(1, 8'h43, 0,   0, 8'h00, 0,  0,   0,  0,  4));
      vecs.push_back(mk(0, 8'h00, 0,   0, 8'h00, 0,  0,   1,  0,  4));
      vecs.push_back(mk(1, 8'h0D, 0,   0, 8'h00, 0,  0,   0,  0,  4));
      vecs.push_back(mk(0, 8'h00, 0,   0, 8'h00, 0,  0,   0,  0,  4));
      vecs.push_back(mk(0, 8'h00, 0,   0, 8'h00, 0,  0,   0,  0,  4));

      for (int i = 0; i < vecs.size(); i++) begin
         iRX_VALID  = vecs[i].vld;
         iRX_DATA   = vecs[i].dat;
         iFIFO_FULL = vecs[i].full;
         @(negedge clk);
         check($sformatf("vec%0d_wr_en", i), oWR_EN, vecs[i].wr);
         if (vecs[i].wr) check($sformatf("vec%0d_wr_data", i), oWR_DATA, vecs[i].wd);
         check($sformatf("vec%0d_finish", i), oFINISH, vecs[i].fin);
         check($sformatf("vec%0d_busy", i), oBUSY, vecs[i].busy);
         check($sformatf("vec%0d_clean", i), oCLEAN, vecs[i].cln);
         check($sformatf("vec%0d_ovf", i), oOVERFLOW, vecs[i].ovf);
         check($sformatf("vec%0d_len", i), oLINE_LEN, vecs[i].len);
         tick();
      end
      iRX_VALID = 1'b0;
      iFIFO_FULL = 1'b0;
      m_fin_target = finish_cnt;
      m_clean_exp = clean_cnt;
      m_last_len = 4;
      sb_en = 1'b1;

      // Overflow: 18 digits into a 16-byte buffer, flag is sticky across the commit.
      for (int i = 0; i < 18; i++) send_byte(8'(8'h30 + $urandom_range(0, 9)));
      send_byte(8'h0D);
      wait_line_done("ovf_line");
      check("ovf_sticky", oOVERFLOW, 1);
      send_byte(8'h43);
      check("clean_pulse", oCLEAN, 1);
      tick();
      check("clean_once", oCLEAN, 0);
      check_flags("after_clear");

      // Edit sequence (backspace honoured only when the macro is defined)
      send_str("12");
      send_byte(8'h08);
      send_str("3");
      send_byte(8'h0D);
      wait_line_done("edit");

      // Byte arriving while busy is dropped; next line starts empty.
      send_str("9");
      send_byte(8'h0D);
      send_str("8");
      wait_line_done("busy_drop");
      send_byte(8'h0D);
      repeat (5) tick();
      check("empty_cr_no_finish", finish_cnt, m_fin_target);
      send_str("55c");
      send_byte(8'h0D);
      repeat (5) tick();
      check("clear_then_cr_no_finish", finish_cnt, m_fin_target);
      check_flags("boundary");

      // Reset in the middle of a flush
      sb_en = 1'b0;
      send_str("1234");
      send_byte(8'h0D);
      seen = 0;
      for (int i = 0; i < 20 && seen < 2; i++) begin
         @(negedge clk);
         if (oWR_EN) seen++;
      end
      tick();
      check("midflush_two_writes", seen, 2);
      check("pre_reset_wr_en", oWR_EN, 1);
      reset = 1'b1;
      #1;
      check("midrst_wr_en", oWR_EN, 0);
      check("midrst_wr_data", oWR_DATA, 8'h00);
      check("midrst_busy", oBUSY, 0);
      check("midrst_finish", oFINISH, 0);
      check("midrst_clean", oCLEAN, 0);
      check("midrst_line_len", oLINE_LEN, 0);
      check("midrst_ovf", oOVERFLOW, 0);
      tick();
      reset = 1'b0;
      m_line.delete();
      exp_q.delete();
      m_busy = 1'b0;
      m_ovf = 1'b0;
      m_fin_target = finish_cnt;
      repeat (8) tick();
      check("midrst_no_finish", finish_cnt, m_fin_target);
      sb_en = 1'b1;
      send_str("7");
      send_byte(8'h0D);
      wait_line_done("post_reset");

      // Randomized lines with random FIFO back-pressure
      stall_mode = 1'b1;
      for (int it = 0; it < 60; it++) begin
         repeat ($urandom_range(0, 2)) tick();
         n = $urandom_range(0, 20);
         for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0) send_byte(($urandom_range(0, 1) == 0) ? 8'h43 : 8'h63);
            else if (r <= 2) send_byte(junk[$urandom_range(0, 4)]);
            else send_byte(8'(8'h30 + $urandom_range(0, 9)));
         end
         send_byte(8'h0D);
         if (m_busy) begin
            if ($urandom_range(0, 1) == 1) send_byte(8'(8'h30 + $urandom_range(0, 9)));
            wait_line_done($sformatf("rnd%0d", it));
         end
         tick();
         check_flags($sformatf("rnd%0d", it));
      end
      stall_mode = 1'b0;
      tick();
      iFIFO_FULL = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
